// File: rtl/axil_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit registers with parallel outputs and write pulses.
// One outstanding write and one outstanding read; the two channels are fully independent.
module axil_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IdxW   = ADDR_WIDTH - 2;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e                     w_state_q, w_state_d;
  r_state_e                     r_state_q, r_state_d;
  logic                         awready_q, awready_d;
  logic                         wready_q, wready_d;
  logic                         aw_held_q, aw_held_d;
  logic                         w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]        awaddr_q, awaddr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
  logic                         arready_q, arready_d;
  logic                         rvalid_q, rvalid_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;

  logic                         aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [31:0]                  wr_data;
  logic [3:0]                   wr_strb;
  logic [IdxW-1:0]              wr_idx, ar_idx;
  logic                         wr_valid, ar_valid;
  logic [31:0]                  rd_val;
  logic                         unused_sigs;

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  // A channel captured in an earlier cycle wins over the live bus value.
  assign wr_addr  = aw_held_q ? awaddr_q : S_AXI_AWADDR;
  assign wr_data  = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb  = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign wr_idx   = wr_addr[ADDR_WIDTH-1:2];
  assign wr_valid = 32'(wr_idx) < NUM_REGS;
  assign ar_idx   = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign ar_valid = 32'(ar_idx) < NUM_REGS;

  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (ar_idx == IdxW'(k)) rd_val = regs_q[k];
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    unique case (w_state_q)
      WIdle: begin
        awready_d = !aw_held_q;
        wready_d  = !w_held_q;
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wready_d = 1'b0;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_valid ? Okay : SlvErr;
          w_state_d = WResp;
          if (wr_valid) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
              if (wr_idx == IdxW'(k)) begin
                wr_pulse_d[k] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                end
              end
            end
          end
        end
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read data samples regs_q, so a same-edge write is not visible (read-old).
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = ar_valid ? Okay : SlvErr;
          r_state_d = RData;
        end
      end
      RData: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q  <= WIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= Okay;
      wr_pulse_q <= '0;
      regs_q     <= '0;
      r_state_q  <= RIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= Okay;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_out       = regs_q;
  assign wr_pulse      = wr_pulse_q;

endmodule
